// File: rtl/chip8_mem_pkg.sv
// Shared constants and types for the CHIP-8 system RAM arbiter.
package chip8_mem_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NPORTS = 3;
    localparam int unsigned PORT_W = 2;

    typedef logic [PORT_W-1:0] port_t;

    localparam port_t PORT_CPU  = 2'd0;
    localparam port_t PORT_BLIT = 2'd1;
    localparam port_t PORT_LOAD = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // One read-tracking pipeline slot
    typedef struct packed {
        logic  valid;
        port_t port;
    } rd_tag_t;

    function automatic logic [NPORTS-1:0] port_onehot(port_t p);
        return NPORTS'(1) << p;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the RAM arbiter: flattened per-port request payloads and responses.
interface mem_arbiter_if;
    import chip8_mem_pkg::*;

    logic [NPORTS-1:0]        req;
    logic [NPORTS-1:0]        lock;
    logic [NPORTS-1:0]        we;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS*DATA_W-1:0] wdata;
    logic [NPORTS-1:0]        gnt;
    logic [NPORTS-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping modulo NPORTS.
module rr_pick
    import chip8_mem_pkg::*;
(
    input  logic [NPORTS-1:0] req_i,
    input  port_t             last_i,
    output logic [NPORTS-1:0] pick_o,
    output port_t             idx_o,
    output logic              any_o
);

    int unsigned cand;
    port_t       cand_p;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand   = 0;
        cand_p = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            cand   = (32'(last_i) + k) % NPORTS;
            cand_p = PORT_W'(cand);
            if (!any_o && req_i[cand_p]) begin
                any_o  = 1'b1;
                idx_o  = cand_p;
                pick_o = port_onehot(cand_p);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPU, blitter and loader: round-robin grants, lockable bursts,
// registered RAM controls and a two-stage read tracker that returns rvalid two cycles after gnt.
module mem_arbiter
    import chip8_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    arb_state_e state_q, state_d;
    port_t      owner_q, owner_d;
    port_t      last_q,  last_d;

    logic [NPORTS-1:0] req_m;
    logic [NPORTS-1:0] pick;
    port_t             pick_idx;
    logic              pick_any;

    logic [ADDR_W-1:0] addr_a  [NPORTS];
    logic [DATA_W-1:0] wdata_a [NPORTS];

    logic              ram_en_q, ram_wr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_in_q;
    rd_tag_t           tag_q;
    logic [NPORTS-1:0] rvalid_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
        assign addr_a[p]  = bus.addr[p*ADDR_W +: ADDR_W];
        assign wdata_a[p] = bus.wdata[p*DATA_W +: DATA_W];
    end

    // While a burst is owned, only the owner is visible to the picker
    assign req_m = (state_q == OWNED) ? (bus.req & port_onehot(owner_q)) : bus.req;

    rr_pick u_pick (
        .req_i  (req_m),
        .last_i (last_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign bus.gnt    = pick;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = ram_out;

    assign ram_en   = ram_en_q;
    assign ram_wr   = ram_wr_q;
    assign ram_addr = ram_addr_q;
    assign ram_in   = ram_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= PORT_CPU;
            last_q  <= PORT_LOAD;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    last_d = pick_idx;
                    if (bus.lock[pick_idx]) begin
                        state_d = OWNED;
                        owner_d = pick_idx;
                    end
                end
            end
            OWNED: begin
                // Owner dropping req releases the lock without a grant
                if (pick_any) begin
                    last_d = pick_idx;
                    if (!bus.lock[pick_idx]) state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            tag_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            ram_en_q <= pick_any;
            ram_wr_q <= pick_any & bus.we[pick_idx];
            if (pick_any) begin
                ram_addr_q <= addr_a[pick_idx];
                ram_in_q   <= wdata_a[pick_idx];
            end
            tag_q    <= '{valid: pick_any & ~bus.we[pick_idx], port: pick_idx};
            rvalid_q <= tag_q.valid ? port_onehot(tag_q.port) : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, shadow memory, queue of due read responses).
module tb_mem_arbiter;
    import chip8_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    logic        ram_en, ram_wr;
    logic [11:0] ram_addr;
    logic [7:0]  ram_in;
    logic [7:0]  ram_out;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_in   (ram_in),
        .ram_out  (ram_out)
    );

    function automatic logic [7:0] init_val(int i);
        if (i == 12'h200) return 8'h12;
        if (i == 12'h300) return 8'h3C;
        return 8'((i * 29 + 7) ^ (i >> 5));
    endfunction

    // Read-first single-port RAM with one-cycle registered read
    logic [7:0] ram [4096];
    logic preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
        end else if (ram_en) begin
            if (ram_wr) ram[ram_addr] <= ram_in;
            ram_out <= ram[ram_addr];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [2:0]  d_req, d_lock, d_we;
    logic [11:0] d_addr [3];
    logic [7:0]  d_wdata [3];

    typedef struct {
        int         due;
        int         port;
        logic [7:0] data;
    } rd_t;
    rd_t        rd_q[$];
    logic [7:0] mem_m [4096];
    int         m_owner, m_last;
    logic       m_en, m_wr;
    logic [11:0] m_addr;
    logic [7:0]  m_in;

    logic [2:0]  exp_gnt, exp_rvalid, o_gnt, o_rvalid;
    logic [7:0]  exp_rdata, o_rdata, exp_in, o_in;
    logic        exp_en, exp_wr, o_en, o_wr;
    logic [11:0] exp_addr, o_addr;

    task automatic clear_req();
        d_req = '0; d_lock = '0; d_we = '0;
        for (int p = 0; p < 3; p++) begin d_addr[p] = '0; d_wdata[p] = '0; end
    endtask

    task automatic set_req(int p, bit r, bit l, bit w, logic [11:0] a, logic [7:0] d);
        d_req[p] = r; d_lock[p] = l; d_we[p] = w; d_addr[p] = a; d_wdata[p] = d;
    endtask

    task automatic apply_inputs();
        bus.req   = d_req;
        bus.lock  = d_lock;
        bus.we    = d_we;
        bus.addr  = {d_addr[2], d_addr[1], d_addr[0]};
        bus.wdata = {d_wdata[2], d_wdata[1], d_wdata[0]};
    endtask

    // One clock of stimulus; fills exp_* from the model and o_* from the DUT, then advances the model
    task automatic tick();
        int g;
        g = -1;
        apply_inputs();
        if (m_owner >= 0) begin
            if (d_req[m_owner]) g = m_owner;
        end else begin
            for (int k = 1; k <= 3; k++)
                if (g < 0 && d_req[(m_last + k) % 3]) g = (m_last + k) % 3;
        end
        exp_gnt  = (g >= 0) ? (3'b001 << g) : 3'b000;
        exp_en   = m_en;  exp_wr = m_wr;  exp_addr = m_addr;  exp_in = m_in;
        exp_rvalid = '0;  exp_rdata = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            exp_rvalid = 3'b001 << rd_q[0].port;
            exp_rdata  = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        @(negedge clk);
        o_gnt = bus.gnt;  o_rvalid = bus.rvalid;  o_rdata = bus.rdata;
        o_en = ram_en;  o_wr = ram_wr;  o_addr = ram_addr;  o_in = ram_in;
        if (m_owner >= 0) begin
            if (g < 0 || !d_lock[g]) m_owner = -1;
        end else if (g >= 0 && d_lock[g]) begin
            m_owner = g;
        end
        if (g >= 0) begin
            m_last = g;  m_en = 1'b1;  m_wr = d_we[g];  m_addr = d_addr[g];  m_in = d_wdata[g];
            if (d_we[g]) mem_m[d_addr[g]] = d_wdata[g];
            else rd_q.push_back('{cyc + 2, g, mem_m[d_addr[g]]});
        end else begin
            m_en = 1'b0;  m_wr = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_req();
        apply_inputs();
        m_owner = -1;  m_last = 2;
        m_en = 1'b0;  m_wr = 1'b0;  m_addr = '0;  m_in = '0;
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        preload = 1'b0;
        n_cmp++;
        if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt_rvalid: got %b/%b want 000/000", bus.gnt, bus.rvalid);
        end
        n_cmp++;
        if ({ram_en, ram_wr, ram_addr, ram_in} !== 22'h0) begin
            n_fail++; $display("FAIL reset_ram: got en=%b wr=%b addr=%h in=%h want all 0", ram_en, ram_wr, ram_addr, ram_in);
        end
    endtask

    task automatic test_single_read();
        clear_req();
        set_req(0, 1, 0, 0, 12'h200, 8'h00);
        tick();
        n_cmp++;
        if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt: got %b want 001", o_gnt); end
        clear_req();
        tick();
        n_cmp++;
        if ({o_en, o_wr, o_addr} !== {1'b1, 1'b0, 12'h200}) begin
            n_fail++; $display("FAIL single_ram: got en=%b wr=%b addr=%h want 1 0 200", o_en, o_wr, o_addr);
        end
        tick();
        n_cmp++;
        if (o_rvalid !== 3'b001 || o_rdata !== 8'h12) begin
            n_fail++; $display("FAIL single_rdata: got rvalid=%b rdata=%h want 001 12", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        clear_req();
        for (int p = 0; p < 3; p++) set_req(p, 1, 0, 0, 12'($urandom_range(0, 4095)), 8'h00);
        for (int i = 0; i < 11; i++) begin
            if (i == 9) clear_req();
            tick();
            want = (i < 9) ? (3'b001 << ((i + 1) % 3)) : 3'b000;
            n_cmp++;
            if (o_gnt !== want) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, o_gnt, want); end
            n_cmp++;
            if (o_rvalid !== exp_rvalid || (exp_rvalid != 0 && o_rdata !== exp_rdata)) begin
                n_fail++; $display("FAIL rr_rdata[%0d]: got %b/%h want %b/%h", i, o_rvalid, o_rdata, exp_rvalid, exp_rdata);
            end
            for (int p = 0; p < 3; p++)
                if (i < 9 && want[p]) d_addr[p] = 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic test_burst_lock();
        clear_req();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) set_req(0, 1, 0, 0, 12'h123, 8'h00);
            else d_req[0] = 1'b0;
            if (i < 4) set_req(1, 1, (i < 3), 0, 12'($urandom_range(0, 4095)), 8'h00);
            else d_req[1] = 1'b0;
            tick();
            n_cmp++;
            if (i < 5 && (o_gnt[0] !== (i == 4) || o_gnt[1] !== (i < 4))) begin
                n_fail++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, o_gnt, (i == 4) ? 3'b001 : 3'b010);
            end else if (i >= 5 && o_rvalid !== exp_rvalid) begin
                n_fail++; $display("FAIL burst_rvalid[%0d]: got %b want %b", i, o_rvalid, exp_rvalid);
            end
        end
    endtask

    task automatic test_write_read();
        clear_req();
        set_req(2, 1, 0, 1, 12'h050, 8'hA5);
        tick();
        n_cmp++;
        if (o_gnt !== 3'b100) begin n_fail++; $display("FAIL wr_gnt: got %b want 100", o_gnt); end
        clear_req();
        set_req(0, 1, 0, 0, 12'h050, 8'h00);
        tick();
        n_cmp++;
        if ({o_en, o_wr, o_addr, o_in} !== {1'b1, 1'b1, 12'h050, 8'hA5}) begin
            n_fail++; $display("FAIL wr_ram: got en=%b wr=%b addr=%h in=%h want 1 1 050 a5", o_en, o_wr, o_addr, o_in);
        end
        clear_req();
        tick();
        tick();
        n_cmp++;
        if (o_rvalid !== 3'b001 || o_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL raw_rdata: got %b/%h want 001/a5", o_rvalid, o_rdata);
        end
        set_req(0, 1, 0, 0, 12'h300, 8'h00);
        tick();
        clear_req();
        set_req(2, 1, 0, 1, 12'h300, 8'h77);
        tick();
        clear_req();
        tick();
        n_cmp++;
        if (o_rvalid !== 3'b001 || o_rdata !== 8'h3C) begin
            n_fail++; $display("FAIL read_first: got %b/%h want 001/3c", o_rvalid, o_rdata);
        end
        set_req(0, 1, 0, 0, 12'h300, 8'h00);
        tick();
        clear_req();
        tick();
        tick();
        n_cmp++;
        if (o_rvalid !== 3'b001 || o_rdata !== 8'h77) begin
            n_fail++; $display("FAIL after_write: got %b/%h want 001/77", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_release();
        clear_req();
        set_req(2, 1, 1, 0, 12'h0AB, 8'h00);
        tick();
        n_cmp++;
        if (o_gnt !== 3'b100) begin n_fail++; $display("FAIL rel_lock_gnt: got %b want 100", o_gnt); end
        d_req[2] = 1'b0;
        set_req(0, 1, 0, 0, 12'h111, 8'h00);
        set_req(1, 1, 0, 0, 12'h222, 8'h00);
        tick();
        n_cmp++;
        if (o_gnt !== 3'b000) begin n_fail++; $display("FAIL rel_gap_gnt: got %b want 000", o_gnt); end
        tick();
        n_cmp++;
        if (o_en !== 1'b0 || o_gnt !== 3'b001) begin
            n_fail++; $display("FAIL rel_resume: got en=%b gnt=%b want 0 001", o_en, o_gnt);
        end
        d_req[0] = 1'b0;
        tick();
        n_cmp++;
        if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL rel_next_gnt: got %b want 010", o_gnt); end
        clear_req();
        repeat (2) begin
            tick();
            n_cmp++;
            if (o_rvalid !== exp_rvalid || (exp_rvalid != 0 && o_rdata !== exp_rdata)) begin
                n_fail++; $display("FAIL rel_drain: got %b/%h want %b/%h", o_rvalid, o_rdata, exp_rvalid, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_req();
        set_req(1, 1, 1, 0, 12'h0F0, 8'h00);
        tick();
        set_req(1, 1, 1, 0, 12'h0F1, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rvalid, ram_en, ram_wr, ram_addr, ram_in} !== 25'h0) begin
            n_fail++; $display("FAIL rst_async: got rvalid=%b en=%b wr=%b addr=%h in=%h want all 0", bus.rvalid, ram_en, ram_wr, ram_addr, ram_in);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({o_rvalid, o_en, o_wr, o_addr, o_in} !== 25'h0) begin
                n_fail++; $display("FAIL rst_quiet[%0d]: got rvalid=%b en=%b addr=%h in=%h want all 0", i, o_rvalid, o_en, o_addr, o_in);
            end
        end
        for (int p = 0; p < 3; p++) set_req(p, 1, 0, 0, 12'h400 + 12'(p), 8'h00);
        tick();
        n_cmp++;
        if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 001", o_gnt); end
        clear_req();
        repeat (2) tick();
        n_cmp++;
        if (o_rvalid !== 3'b001 || o_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rst_first_rdata: got %b/%h want 001/%h", o_rvalid, o_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        bit pend [3];
        for (int p = 0; p < 3; p++) pend[p] = 1'b0;
        clear_req();
        for (int i = 0; i < 402; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (i >= 400) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    set_req(p, 1, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                            12'h600 + 12'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                end else if (pend[p] && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
                d_req[p] = pend[p];
            end
            tick();
            n_cmp++;
            if (o_gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, o_gnt, exp_gnt); end
            n_cmp++;
            if (o_rvalid !== exp_rvalid || (exp_rvalid != 0 && o_rdata !== exp_rdata)) begin
                n_fail++; $display("FAIL rnd_rdata[%0d]: got %b/%h want %b/%h", i, o_rvalid, o_rdata, exp_rvalid, exp_rdata);
            end
            n_cmp++;
            if ({o_en, o_wr, o_addr, o_in} !== {exp_en, exp_wr, exp_addr, exp_in}) begin
                n_fail++; $display("FAIL rnd_ram[%0d]: got %b %b %h %h want %b %b %h %h", i, o_en, o_wr, o_addr, o_in, exp_en, exp_wr, exp_addr, exp_in);
            end
            for (int p = 0; p < 3; p++) if (exp_gnt[p]) pend[p] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_m[i] = init_val(i);
        clear_req();
        apply_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_lock();
        test_write_read();
        test_release();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 4 KiB CHIP-8 system RAM among the CPU, the blitter and the ROM/font loader. Requesters issue single-beat read/write requests with a req/gnt handshake. The arbiter drives the RAM control signals from registers and returns read data with a per-port valid strobe. It sits between the requesters and the RAM instance in the top level.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 8, RAM data width
- `NPORTS`, 3, requester count; port 0 = CPU, 1 = blitter, 2 = loader
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `req`  in  NPORTS  per-port request; held with its payload until `gnt`
- `lock`  in  NPORTS  keep ownership after this beat (burst); sampled with `req`
- `we`  in  NPORTS  1 = write, 0 = read
- `addr`  in  NPORTS*ADDR_W  flattened addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- `wdata`  in  NPORTS*DATA_W  flattened write data
- `gnt`  out  NPORTS  one-hot, combinational; beat accepted this cycle
- `rvalid`  out  NPORTS  one-hot, registered; `rdata` valid for that port
- `rdata`  out  DATA_W  RAM read data, direct from `ram_out`
- `ram_en`, `ram_wr`  out  1  registered RAM enable and write strobe
- `ram_addr`  out  ADDR_W  registered RAM address
- `ram_in`  out  DATA_W  registered RAM write data
- `ram_out`  in  DATA_W  RAM read data; 1-cycle registered-read RAM

## Operation
- States: IDLE (no owner) and OWNED (a port holds a lock). Encoding is 1 bit plus a 2-bit `owner`.
- IDLE:
  - Grant the requesting port found first in round-robin order, starting at `last+1` mod NPORTS.
  - `last` resets to NPORTS-1, so port 0 wins first.
  - Granted with `lock`=1 -> go to OWNED with `owner`=that port; otherwise stay in IDLE.
- OWNED:
  - Only `owner` may be granted. Other requests wait, with `gnt`=0.
  - Owner beat with `lock`=0 -> grant it, then go to IDLE.
  - Owner drops `req` -> release: go to IDLE next cycle and issue no grant that cycle.
- `last` updates to the granted port on every grant.
- On a grant at cycle N, the next clock edge registers `ram_en`=1, `ram_wr`=`we[p]`, `ram_addr`=`addr[p]` and `ram_in`=`wdata[p]`.
- With no grant, `ram_en`=0 and `ram_wr`=0. Address and data hold their previous values.
- Read tracking: a 2-stage shift of {valid, port}. Reads only: a read granted at N produces `rvalid[p]`=1 during N+2. Writes produce no `rvalid`.
- Back-to-back grants are allowed every cycle: throughput is one beat per clock, and read responses return in grant order.
- Addresses pass through unchanged. No wrap or bounds logic: `ADDR_W` bits roll over naturally.

## Timing
- Reset (async assert, sync deassert by top level):
  - `gnt`=0, `rvalid`=0, `ram_en`=0, `ram_wr`=0, `ram_addr`=0, `ram_in`=0.
  - State=IDLE, `last`=NPORTS-1, pipeline cleared.
- `gnt` is a combinational function of `req`, `lock`, state, `owner` and `last`. It never depends on `rdata`.
- Read latency is exactly 2 cycles from `gnt` to `rvalid`. Write completes at the RAM on the edge ending cycle N+1.
- Simultaneous requests resolve in one cycle with no bubble.
- Read then write to the same address in consecutive cycles: the read returns the old data (RAM read-first).
- A request deasserted before `gnt` is legal. It is dropped without side effects.
- Reset mid-burst or with reads in flight: the owner is released and pending `rvalid` pulses are discarded, never emitted after `rst_n` rises.

## Structure
- Package `chip8_mem_pkg` holds:
  - `ADDR_W`, `DATA_W`, `NPORTS`.
  - Port index constants `PORT_CPU`=0, `PORT_BLIT`=1, `PORT_LOAD`=2.
  - The arbiter state enum {IDLE, OWNED}.
- One sub-module: `rr_pick`. It is purely combinational: inputs are the request vector and `last`; outputs are a one-hot pick and an index. It is instantiated once, fed with `req` masked to `owner` when in OWNED.

## Test plan
- After reset, CPU alone reads 0x200 with RAM[0x200]=0x12 -> `gnt[0]` in cycle 0, `ram_addr`=0x200 in cycle 1, `rvalid[0]`=1 with `rdata`=0x12 in cycle 2.
- All three ports request reads continuously, with `lock`=0 -> grants rotate 0,1,2,0,… one per cycle; each `rvalid` matches its own address data, in order.
- Blitter issues a 4-beat burst with `lock`=1 on beats 1–3 while the CPU requests -> CPU `gnt`=0 for 4 cycles, then granted in cycle 5.
- Loader writes 0xA5 to 0x050, then the CPU reads 0x050 in the next cycle -> CPU `rdata`=0xA5. Back-to-back read-then-write to 0x300 -> the read returns the pre-write value.
- `rst_n` pulsed low while 2 reads are in flight and the blitter holds a lock -> no `rvalid` afterwards, all RAM outputs 0; the first post-reset grant goes to port 0.
- Requester drops `req` during OWNED -> one idle cycle with `ram_en`=0, then normal round-robin resumes from `last`+1.
